// File: rtl/platform_pkg.sv
// Shared constants, slot record and FSM state types for the platform overlay stage.
package platform_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned PLAT_H   = 8;

    typedef struct packed {
        logic        valid;
        logic [10:0] x0;
        logic [10:0] y0;
        logic [9:0]  width;
        logic [11:0] color;
    } slot_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} scroll_state_t;

    // Half-open span test in 12 bits so base+len never wraps back into range.
    function automatic logic in_span(input logic [10:0] pos, input logic [10:0] base,
                                     input logic [10:0] len);
        logic [11:0] end_pos;
        end_pos = {1'b0, base} + {1'b0, len};
        return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} < end_pos);
    endfunction

endpackage

// File: rtl/platform_line_scanner.sv
// Per-line platform visibility scan: one slot per cycle into a shadow mask, copied to the active mask at the end.
module platform_line_scanner
    import platform_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 16,
    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          x,
    input  logic [10:0]          y,
    output logic [IDX_W-1:0]     slot_idx,
    input  logic                 cur_valid,
    input  logic [10:0]          cur_ey,
    output logic [NUM_SLOTS-1:0] mask
);

    scan_state_t          state;
    logic [10:0]          ty;
    logic [NUM_SLOTS-1:0] shadow_mask;
    logic [NUM_SLOTS-1:0] active_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slot_idx    <= '0;
            ty          <= '0;
            shadow_mask <= '0;
            active_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (x == 11'(H_ACTIVE)) begin
                        state    <= SCAN;
                        slot_idx <= '0;
                        ty       <= (y == 11'(V_TOTAL - 1)) ? '0 : y + 11'd1;
                    end
                end
                SCAN: begin
                    // The table is read live, so edits land only in slots not yet visited.
                    if (cur_valid && in_span(ty, cur_ey, 11'(PLAT_H)))
                        shadow_mask[slot_idx] <= 1'b1;
                    if (slot_idx == IDX_W'(NUM_SLOTS - 1))
                        state <= DONE;
                    else
                        slot_idx <= slot_idx + 1'b1;
                end
                DONE: begin
                    active_mask <= shadow_mask;
                    shadow_mask <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mask = active_mask;

endmodule

// File: rtl/chu_vga_platform_core.sv
// Platform overlay video slot: register table, line scanner and zero-latency pixel mux.
// Define PLATFORM_SCROLL_EN to build in the frame-driven vertical scroll engine.
module chu_vga_platform_core
    import platform_pkg::*;
#(
    parameter int CD        = 12,
    parameter int NUM_SLOTS = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    slot_t                slots [NUM_SLOTS];
    logic                 bypass;
    logic [10:0]          scroll_off;
    logic                 wr_en, tbl_we, ctl_we;
    logic [3:0]           wr_slot;
    logic [IDX_W-1:0]     scan_idx;
    logic [NUM_SLOTS-1:0] mask;
    logic                 hit_found;
    logic                 unused_bits;

    assign wr_en       = cs & write;
    assign tbl_we      = wr_en & ~addr[13];
    assign ctl_we      = wr_en & addr[13];
    assign wr_slot     = addr[5:2];
    assign unused_bits = ^{addr[12:6], wr_data[31:13]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++)
                slots[i] <= '0;
        end else if (tbl_we && (32'(wr_slot) < NUM_SLOTS)) begin
            case (addr[1:0])
                2'd0: slots[wr_slot].x0    <= wr_data[10:0];
                2'd1: slots[wr_slot].y0    <= wr_data[10:0];
                2'd2: slots[wr_slot].width <= wr_data[9:0];
                default: begin
                    slots[wr_slot].valid <= wr_data[12];
                    slots[wr_slot].color <= wr_data[11:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bypass <= 1'b0;
        else if (ctl_we && addr[1:0] == 2'd0)
            bypass <= wr_data[0];
    end

`ifdef PLATFORM_SCROLL_EN
    scroll_state_t scroll_state;
    logic [7:0]    scroll_step;
    logic [7:0]    scroll_cnt;
    logic          frame_tick;

    assign frame_tick = (x == 11'd0) && (y == 11'(V_ACTIVE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_state <= S_IDLE;
            scroll_step  <= '0;
            scroll_cnt   <= '0;
            scroll_off   <= '0;
        end else begin
            if (ctl_we && addr[1:0] == 2'd1)
                scroll_step <= wr_data[7:0];
            // A go write reloads the count from any state; zero cancels outright.
            if (ctl_we && addr[1:0] == 2'd2) begin
                scroll_cnt   <= wr_data[7:0];
                scroll_state <= (wr_data[7:0] != 8'd0) ? S_WAIT : S_IDLE;
            end else begin
                case (scroll_state)
                    S_WAIT: if (frame_tick) scroll_state <= S_STEP;
                    S_STEP: begin
                        scroll_off   <= scroll_off + {3'b000, scroll_step};
                        scroll_cnt   <= scroll_cnt - 8'd1;
                        scroll_state <= (scroll_cnt == 8'd1) ? S_IDLE : S_WAIT;
                    end
                    default: scroll_state <= S_IDLE;
                endcase
            end
        end
    end
`else
    assign scroll_off = '0;
`endif

    platform_line_scanner #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .slot_idx  (scan_idx),
        .cur_valid (slots[scan_idx].valid),
        .cur_ey    (slots[scan_idx].y0 + scroll_off),
        .mask      (mask)
    );

    always_comb begin
        so_rgb    = si_rgb;
        hit_found = 1'b0;
        if (!bypass) begin
            for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
                if (!hit_found && mask[j] &&
                    in_span(x, slots[j].x0, {1'b0, slots[j].width})) begin
                    hit_found = 1'b1;
                    so_rgb    = CD'(slots[j].color);
                end
            end
        end
    end

endmodule

// File: tb/tb_chu_vga_platform_core.sv
// Scoreboard bench for chu_vga_platform_core; scroll checks are built when PLATFORM_SCROLL_EN is defined.
module tb_chu_vga_platform_core;
    import platform_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd700;
    logic [10:0] y = 11'd100;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [11:0] si_rgb = '0;
    logic [11:0] so_rgb;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    chu_vga_platform_core #(
        .CD        (12),
        .NUM_SLOTS (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .y       (y),
        .cs      (cs),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .si_rgb  (si_rgb),
        .so_rgb  (so_rgb)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        x = 11'd700;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic slot_wr(input int s, input int x0, input int y0, input int w,
                           input bit v, input logic [11:0] c);
        bus_wr(14'(s * 4 + 0), 32'(x0));
        bus_wr(14'(s * 4 + 1), 32'(y0));
        bus_wr(14'(s * 4 + 2), 32'(w));
        bus_wr(14'(s * 4 + 3), {19'b0, v, c});
    endtask

    // Runs the end-of-line scan that prepares line ty, then moves y onto ty.
    task automatic scan(input int ty);
        @(posedge clk); #1;
        x = 11'd640;
        y = (ty == 0) ? 11'(V_TOTAL - 1) : 11'(ty - 1);
        @(posedge clk); #1;
        x = 11'd700;
        repeat (17) @(posedge clk);
        #1 y = 11'(ty);
    endtask

    task automatic frame_tick();
        @(posedge clk); #1;
        x = 11'd0; y = 11'(V_ACTIVE);
        @(posedge clk); #1;
        x = 11'd700;
        @(posedge clk); #1;
    endtask

    task automatic pix(input string tag, input int px, input int py, input bit hit,
                       input logic [11:0] color);
        logic [11:0] s;
        exp_t e;
        @(posedge clk); #1;
        s = 12'($urandom_range(0, 4095));
        if (s == color) s = s ^ 12'h001;
        x = 11'(px); y = 11'(py); si_rgb = s;
        e.tag = tag;
        e.exp = hit ? {20'b0, color} : {20'b0, s};
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check(e.tag, {20'b0, so_rgb}, e.exp);
    endtask

    initial begin
        do_reset();
        check("rst_active_mask", 32'(dut.u_scanner.active_mask), 32'd0);
        pix("rst_pass", 120, 203, 1'b0, 12'h0F0);

        slot_wr(0, 100, 200, 64, 1'b1, 12'h0F0);
        scan(203);
        pix("l203_x99", 99, 203, 1'b0, 12'h0F0);
        for (int i = 100; i <= 163; i++)
            pix($sformatf("l203_x%0d", i), i, 203, 1'b1, 12'h0F0);
        pix("l203_x164", 164, 203, 1'b0, 12'h0F0);
        scan(208);
        pix("l208", 120, 208, 1'b0, 12'h0F0);
        scan(207);
        pix("l207", 120, 207, 1'b1, 12'h0F0);
        scan(199);
        pix("l199", 120, 199, 1'b0, 12'h0F0);
        scan(200);
        pix("l200", 100, 200, 1'b1, 12'h0F0);

        bus_wr(14'd3, 32'h0000_00F0);
        slot_wr(2, 140, 200, 20, 1'b1, 12'hF00);
        slot_wr(5, 150, 200, 30, 1'b1, 12'h00F);
        slot_wr(7, 300, 200, 0, 1'b1, 12'h777);
        scan(203);
        pix("ovl_150", 150, 203, 1'b1, 12'hF00);
        pix("ovl_145", 145, 203, 1'b1, 12'hF00);
        pix("ovl_165", 165, 203, 1'b1, 12'h00F);
        pix("slot0_off", 120, 203, 1'b0, 12'h0F0);
        pix("width0", 300, 203, 1'b0, 12'h777);

        bus_wr(14'h2000, 32'd1);
        pix("bypass_on", 150, 203, 1'b0, 12'hF00);
        pix("bypass_on2", 165, 203, 1'b0, 12'h00F);
        bus_wr(14'h2000, 32'd0);
        pix("bypass_off", 150, 203, 1'b1, 12'hF00);

        slot_wr(0, 100, 200, 64, 1'b1, 12'h0F0);
`ifdef PLATFORM_SCROLL_EN
        bus_wr(14'h2001, 32'd4);
        bus_wr(14'h2002, 32'd3);
        frame_tick();
        check("scroll_off_1", 32'(dut.scroll_off), 32'd4);
        frame_tick();
        check("scroll_off_2", 32'(dut.scroll_off), 32'd8);
        frame_tick();
        check("scroll_off_3", 32'(dut.scroll_off), 32'd12);
        check("scroll_idle", 32'(dut.scroll_state), 32'(S_IDLE));
        frame_tick();
        check("scroll_hold", 32'(dut.scroll_off), 32'd12);
        scan(211);
        pix("scr_l211", 120, 211, 1'b0, 12'h0F0);
        scan(212);
        pix("scr_l212", 120, 212, 1'b1, 12'h0F0);
        scan(219);
        pix("scr_l219", 120, 219, 1'b1, 12'h0F0);
        scan(220);
        pix("scr_l220", 120, 220, 1'b0, 12'h0F0);

        bus_wr(14'h2002, 32'd5);
        frame_tick();
        check("go5_step", 32'(dut.scroll_off), 32'd16);
        bus_wr(14'h2002, 32'd0);
        check("go0_idle", 32'(dut.scroll_state), 32'(S_IDLE));
        frame_tick();
        frame_tick();
        check("go0_frozen", 32'(dut.scroll_off), 32'd16);

        do_reset();
        check("rst_scroll_off", 32'(dut.scroll_off), 32'd0);
        bus_wr(14'h2001, 32'd4);
        bus_wr(14'h2002, 32'd1);
        frame_tick();
        check("wrap_off", 32'(dut.scroll_off), 32'd4);
        slot_wr(0, 100, 2045, 64, 1'b1, 12'h0F0);
        scan(0);
        pix("wrap_l0", 120, 0, 1'b0, 12'h0F0);
        scan(1);
        pix("wrap_l1", 120, 1, 1'b1, 12'h0F0);
        scan(8);
        pix("wrap_l8", 120, 8, 1'b1, 12'h0F0);
        scan(9);
        pix("wrap_l9", 120, 9, 1'b0, 12'h0F0);
        slot_wr(0, 100, 200, 64, 1'b1, 12'h0F0);
        bus_wr(14'h2001, 32'd0);
`else
        bus_wr(14'h2001, 32'd4);
        bus_wr(14'h2002, 32'd3);
        frame_tick();
        frame_tick();
        frame_tick();
        check("noscroll_off", 32'(dut.scroll_off), 32'd0);
        scan(203);
        pix("noscroll_l203", 120, 203, 1'b1, 12'h0F0);
        scan(212);
        pix("noscroll_l212", 120, 212, 1'b0, 12'h0F0);
`endif

        // Reset lands a few cycles into a scan that has already marked slot 0.
        @(posedge clk); #1;
        x = 11'd640; y = 11'd202;
        @(posedge clk); #1;
        x = 11'd700;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midscan_shadow", 32'(dut.u_scanner.shadow_mask), 32'd0);
        check("midscan_active", 32'(dut.u_scanner.active_mask), 32'd0);
        pix("midscan_so", 120, 203, 1'b0, 12'h0F0);
        @(posedge clk); #1 reset = 1'b0;
        scan(203);
        pix("post_rst_l203", 120, 203, 1'b0, 12'h0F0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chu_vga_platform_core.md
CHU_VGA_PLATFORM_CORE -- requirements
Module: chu_vga_platform_core

Interface
REQ-001 SHALL have parameter CD, default 12, pixel colour depth.
REQ-002 SHALL have parameter NUM_SLOTS, default 16, number of platform table entries.
REQ-003 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have ports x, y, input, 11 each, current pixel position from the frame counter.
REQ-006 SHALL have ports cs, write, input, 1 each, video-slot select and write strobe.
REQ-007 SHALL have ports addr, input, 14, and wr_data, input, 32, video-slot write address and data.
REQ-008 SHALL have port si_rgb, input, CD, upstream background pixel.
REQ-009 SHALL have port so_rgb, output, CD, pixel stream into the downstream doodle sprite stage.

Function
REQ-010 SHALL decode wr_en = cs & write; addr[13]=0 selects the table, with slot = addr[5:2] and field = addr[1:0].
REQ-011 SHALL decode table fields as: 0 x0 = wr_data[10:0]; 1 y0 = wr_data[10:0]; 2 width = wr_data[9:0]; 3 {valid = wr_data[12], color = wr_data[11:0]}.
REQ-012 SHALL decode addr[13]=1, addr[1:0] as: 0 bypass = wr_data[0]; 1 scroll_step = wr_data[7:0]; 2 scroll_go count = wr_data[7:0]; 3 ignored.
REQ-013 SHALL compute effective row ey_i = (y0_i + scroll_off) mod 2048.
REQ-014 SHALL start the line-scan FSM (IDLE -> SCAN -> DONE -> IDLE) on the cycle x == H_ACTIVE (640), with target line ty = (y == V_TOTAL-1) ? 0 : y+1.
REQ-015 SHALL, in SCAN, test one slot per cycle (index 0..NUM_SLOTS-1) and set shadow bit i iff valid_i && ey_i <= ty < ey_i + PLAT_H, with the comparison done in 12 bits and no wrap.
REQ-016 SHALL, in DONE, copy the shadow mask to the active mask and clear the shadow; one scan takes NUM_SLOTS+1 cycles.
REQ-017 SHALL drive so_rgb combinationally (zero latency): if bypass, si_rgb; else color_j of the lowest index j with mask[j] && x0_j <= x < x0_j + width_j (12-bit sum, no wrap); else si_rgb.
REQ-018 SHALL let a table write during SCAN affect only slots not yet scanned; already-scanned slots take effect on the next line.
REQ-019 SHALL treat width 0 as never hit; extents past x = 639 SHALL be clipped implicitly by blanking.
REQ-020 SHALL run the scroll FSM as S_IDLE -> S_WAIT on a scroll_go write with count > 0; S_WAIT -> S_STEP at frame tick (x == 0 && y == V_ACTIVE); S_STEP: scroll_off += scroll_step (mod 2048) and count -= 1, then -> S_IDLE if count == 0, else -> S_WAIT.
REQ-021 SHALL reload count on a scroll_go write in any state; a write of count 0 SHALL force S_IDLE without stepping.

Reset
REQ-022 SHALL clear all table entries (valid = 0), bypass, scroll_step, count, scroll_off, the shadow mask and the active mask, and put both FSMs in IDLE.
REQ-023 SHALL abort a scan or scroll in progress on reset; so_rgb SHALL equal si_rgb from reset until the first completed scan.

Configuration
REQ-024 SHALL compile in the scroll engine (REQ-020/021) only when PLATFORM_SCROLL_EN is defined.
REQ-025 SHALL, without PLATFORM_SCROLL_EN, hold scroll_off at constant 0, ignore writes to control addresses 1 and 2, and omit the scroll FSM logic.

Structure
REQ-026 SHALL put constants H_ACTIVE=640, V_ACTIVE=480, V_TOTAL=525, PLAT_H=8, the slot struct {valid, x0, y0, width, color} and both FSM state enums in shared package platform_pkg.
REQ-027 SHALL implement the scan FSM, shadow mask and active mask in sub-module platform_line_scanner.

Verification
REQ-028 SHALL check: slot 0 = {x0 100, y0 200, width 64, color 0x0F0, valid}; on line 203, x = 100..163 -> so_rgb = 0x0F0, x = 99 and x = 164 -> si_rgb; line 208 -> si_rgb.
REQ-029 SHALL check: slots 2 and 5 overlap at (150, 203) with colours 0xF00 and 0x00F -> 0xF00.
REQ-030 SHALL check: scroll_step = 4, scroll_go = 3 -> scroll_off = 4, 8, 12 over three frame ticks, then S_IDLE; platform y0 200 then draws on rows 212..219 (PLATFORM_SCROLL_EN defined).
REQ-031 SHALL check: scroll_go = 0 written mid-sequence -> FSM goes to S_IDLE and scroll_off is frozen.
REQ-032 SHALL check: reset asserted mid-SCAN -> next cycle masks = 0 and so_rgb = si_rgb; bypass = 1 -> so_rgb = si_rgb everywhere.
REQ-033 SHALL check: y0 = 2045 with scroll_off = 4 -> ey = 1, platform drawn on rows 1..8.
